// File: rtl/sm83_mem_cycle_if.sv
// Bus bundle between the core-side request logic and the SM83 memory cycle sequencer.
// The master modport is the requester side; the slave modport is the sequencer.
interface sm83_mem_cycle_if;
    logic        req;
    logic        we;
    logic [15:0] apin;
    logic [7:0]  wdata;
    logic        hold;
    logic [7:0]  pd_in;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic [15:0] pa;
    logic [7:0]  pd_out;
    logic        pd_oe;
    logic        rd_n;
    logic        wr_n;
    logic        cs_n;

    modport master (
        output req, we, apin, wdata, hold, pd_in,
        input  busy, done, rdata, pa, pd_out, pd_oe, rd_n, wr_n, cs_n
    );

    modport slave (
        input  req, we, apin, wdata, hold, pd_in,
        output busy, done, rdata, pa, pd_out, pd_oe, rd_n, wr_n, cs_n
    );
endinterface

// File: rtl/sm83_mem_cycle.sv
// SM83 memory bus cycle sequencer: one T1..T4 M-cycle per request, with T3 wait
// extension, external strobe decode and read-data latching.
module sm83_mem_cycle #(
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              reset,
    sm83_mem_cycle_if.slave   bus
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4
    } state_t;

    // External space excludes the internal high page and the VRAM window.
    function automatic logic is_ext(input logic [15:0] adr);
        return (adr < 16'hFE00) && !((adr >= 16'h8000) && (adr <= 16'h9FFF));
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic           capture_s;
    logic [HW-1:0]  hold_cnt_r;
    logic [HW-1:0]  hold_cnt_s;

    logic [15:0]    cyc_adr_r;
    logic           cyc_we_r;
    logic [7:0]     cyc_wd_r;

    logic [15:0]    adr_s;
    logic           we_s;
    logic [7:0]     wd_s;
    logic           ext_s;
    logic           busy_s;
    logic           done_s;
    logic           cs_n_s;
    logic           rd_n_s;
    logic           wr_n_s;
    logic           pd_oe_s;
    logic           rdata_load_s;

    logic           busy_r;
    logic           done_r;
    logic           cs_n_r;
    logic           rd_n_r;
    logic           wr_n_r;
    logic           pd_oe_r;
    logic [7:0]     rdata_r;

    // Next-state decode and hold counter update.
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    capture_s  = 1'b1;
                    hold_cnt_s = '0;
                    state_s    = ST_T1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_T1: state_s = ST_T2;
            ST_T2: state_s = ST_T3;
            ST_T3: begin
                if (!bus.hold || (hold_cnt_r == HOLD_MAX)) begin
                    state_s    = ST_T4;
                end else begin
                    state_s    = ST_T3;
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            ST_T4: begin
                if (bus.req) begin
                    capture_s  = 1'b1;
                    hold_cnt_s = '0;
                    state_s    = ST_T1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = '0;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they register in step with it.
    always_comb begin
        adr_s   = capture_s ? bus.apin  : cyc_adr_r;
        we_s    = capture_s ? bus.we    : cyc_we_r;
        wd_s    = capture_s ? bus.wdata : cyc_wd_r;
        ext_s   = is_ext(adr_s);
        busy_s  = (state_s != ST_IDLE);
        done_s  = (state_s == ST_T4);
        cs_n_s  = !(busy_s && ext_s);
        rd_n_s  = !((state_s inside {ST_T1, ST_T2, ST_T3}) && !we_s && ext_s);
        wr_n_s  = !((state_s inside {ST_T2, ST_T3}) && we_s && ext_s);
        pd_oe_s = (state_s inside {ST_T2, ST_T3, ST_T4}) && we_s && ext_s;
        rdata_load_s = (state_r == ST_T3) && (state_s == ST_T4) && !cyc_we_r;
    end

    // State, hold counter and captured cycle parameters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            cyc_adr_r  <= 16'h0000;
            cyc_we_r   <= 1'b0;
            cyc_wd_r   <= 8'h00;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            cyc_adr_r  <= adr_s;
            cyc_we_r   <= we_s;
            cyc_wd_r   <= wd_s;
        end
    end

    // Registered strobes and status; async reset drops strobes without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            rd_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            pd_oe_r <= 1'b0;
        end else begin
            busy_r  <= busy_s;
            done_r  <= done_s;
            cs_n_r  <= cs_n_s;
            rd_n_r  <= rd_n_s;
            wr_n_r  <= wr_n_s;
            pd_oe_r <= pd_oe_s;
        end
    end

    // Read data is sampled on the clock that leaves T3, whatever the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= 8'h00;
        end else if (rdata_load_s) begin
            rdata_r <= bus.pd_in;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.rdata  = rdata_r;
    assign bus.pa     = cyc_adr_r;
    assign bus.pd_out = cyc_wd_r;
    assign bus.pd_oe  = pd_oe_r;
    assign bus.rd_n   = rd_n_r;
    assign bus.wr_n   = wr_n_r;
    assign bus.cs_n   = cs_n_r;

endmodule

// File: tb/tb_sm83_mem_cycle.sv
// Directed self-checking bench for sm83_mem_cycle; outputs sampled on the falling edge.
module tb_sm83_mem_cycle;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n;

    sm83_mem_cycle_if bus_if ();

    sm83_mem_cycle #(.MAX_HOLD(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_strobes(input string tag, input logic rd, input logic wr,
                                 input logic cs, input logic oe, input logic dn, input logic bz);
        check({tag, ".rd_n"}, 32'(bus_if.rd_n), 32'(rd));
        check({tag, ".wr_n"}, 32'(bus_if.wr_n), 32'(wr));
        check({tag, ".cs_n"}, 32'(bus_if.cs_n), 32'(cs));
        check({tag, ".pd_oe"}, 32'(bus_if.pd_oe), 32'(oe));
        check({tag, ".done"}, 32'(bus_if.done), 32'(dn));
        check({tag, ".busy"}, 32'(bus_if.busy), 32'(bz));
    endtask

    logic [15:0] badr [6];
    logic        bext [6];

    initial begin
        errors = 0;
        checks = 0;
        badr = '{16'hFDFF, 16'hFE00, 16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000};
        bext = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b0;
        bus_if.req = 1'b0;
        bus_if.we = 1'b0;
        bus_if.apin = 16'h0000;
        bus_if.wdata = 8'h00;
        bus_if.hold = 1'b0;
        bus_if.pd_in = 8'h00;
        #1 reset = 1'b1;
        #2;
        check_strobes("rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.pa", 32'(bus_if.pa), 32'(16'h0000));
        check("rst.rdata", 32'(bus_if.rdata), 32'(8'h00));
        check("rst.pd_out", 32'(bus_if.pd_out), 32'(8'h00));
        @(negedge clk);
        reset = 1'b0;
        step();
        check_strobes("idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // 1: read C000
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.apin = 16'hC000; bus_if.pd_in = 8'h5A;
        step(); bus_if.req = 1'b0;
        check_strobes("r1.T1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r1.pa", 32'(bus_if.pa), 32'(16'hC000));
        step(); check_strobes("r1.T2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); check_strobes("r1.T3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("r1.rdata_T3", 32'(bus_if.rdata), 32'(8'h00));
        step(); check_strobes("r1.T4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("r1.rdata", 32'(bus_if.rdata), 32'(8'h5A));
        step(); check_strobes("r1.idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r1.pa_idle", 32'(bus_if.pa), 32'(16'hC000));

        // 2: write 2000
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.apin = 16'h2000; bus_if.wdata = 8'h3C;
        bus_if.pd_in = 8'h77;
        step(); bus_if.req = 1'b0;
        check_strobes("w2.T1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); check_strobes("w2.T2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("w2.pd_out", 32'(bus_if.pd_out), 32'(8'h3C));
        step(); check_strobes("w2.T3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(); check_strobes("w2.T4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("w2.rdata", 32'(bus_if.rdata), 32'(8'h5A));
        step(); check_strobes("w2.idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: internal read FF44 still latches, VRAM write 8123 stays off the pins
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.apin = 16'hFF44; bus_if.pd_in = 8'hA5;
        step(); bus_if.req = 1'b0;
        check_strobes("r3.T1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("r3.pa", 32'(bus_if.pa), 32'(16'hFF44));
        step(); step(); check_strobes("r3.T3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); check_strobes("r3.T4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("r3.rdata", 32'(bus_if.rdata), 32'(8'hA5));
        step();
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.apin = 16'h8123; bus_if.wdata = 8'h99;
        step(); bus_if.req = 1'b0;
        check("w3.pa", 32'(bus_if.pa), 32'(16'h8123));
        step(); check_strobes("w3.T2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); step(); check_strobes("w3.T4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("w3.rdata", 32'(bus_if.rdata), 32'(8'hA5));
        step();

        // Address decode boundaries
        for (int i = 0; i < 6; i++) begin
            bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.apin = badr[i];
            step(); bus_if.req = 1'b0;
            check($sformatf("bnd%04h.cs_n", badr[i]), 32'(bus_if.cs_n), 32'(!bext[i]));
            check($sformatf("bnd%04h.rd_n", badr[i]), 32'(bus_if.rd_n), 32'(!bext[i]));
            step(); step(); step(); step();
        end

        // 4: hold for 3 clocks in T3, pd_in changes before the exit clock
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.apin = 16'h4000; bus_if.pd_in = 8'h11;
        step(); bus_if.req = 1'b0; bus_if.hold = 1'b1;
        step(); step();
        check_strobes("h4.T3a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); step(); step();
        check_strobes("h4.T3d", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("h4.rdata_hold", 32'(bus_if.rdata), 32'(8'hA5));
        bus_if.hold = 1'b0; bus_if.pd_in = 8'h99;
        step(); check_strobes("h4.T4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("h4.rdata", 32'(bus_if.rdata), 32'(8'h99));
        step();

        // 4b: hold stuck high -> T3 lasts MAX_HOLD+1 clocks
        bus_if.req = 1'b1; bus_if.apin = 16'h1234; bus_if.hold = 1'b1; bus_if.pd_in = 8'h42;
        step(); bus_if.req = 1'b0;
        step(); step();
        n = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("h4b.t3_len", 32'(n), 32'd16);
        check("h4b.rdata", 32'(bus_if.rdata), 32'(8'h42));
        bus_if.hold = 1'b0;
        step();
        check("h4b.idle", 32'(bus_if.busy), 32'(1'b0));

        // 5: back-to-back reads 0100/0101/0102
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.apin = 16'h0100;
        step();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("b2b%0d.done", k), 32'(bus_if.done), 32'((k % 4) == 3));
            check($sformatf("b2b%0d.rd_n", k), 32'(bus_if.rd_n), 32'((k % 4) == 3));
            check($sformatf("b2b%0d.pa", k), 32'(bus_if.pa), 32'(16'h0100 + 16'(k / 4)));
            check($sformatf("b2b%0d.busy", k), 32'(bus_if.busy), 32'(1'b1));
            bus_if.apin = 16'h0101 + 16'(k / 4);
            bus_if.req = (k < 8);
            step();
        end
        check("b2b.idle", 32'(bus_if.busy), 32'(1'b0));

        // 6: reset during T2 of a write
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.apin = 16'h3000; bus_if.wdata = 8'h42;
        step(); bus_if.req = 1'b0;
        step(); check_strobes("rs6.T2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1 check_strobes("rs6.async", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(); check_strobes("rs6.after", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rs6.rdata", 32'(bus_if.rdata), 32'(8'h00));
        step(); step();
        check_strobes("rs6.stay", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
